// File: rtl/spi_loader_slave_if.sv
// Write port of the SPI program loader: one word per valid/ready handshake.
interface spi_loader_slave_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int WORD_WIDTH = 32
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [WORD_WIDTH-1:0] wr_data;

  // Loader side produces words.
  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  // Memory side consumes words.
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/spi_loader_slave.sv
// SPI target receiver: oversampled SCLK/SS/MOSI, LSB-first word deserializer,
// auto-addressed valid/ready write port and MISO loopback of the previous word.
module spi_loader_slave #(
  parameter int ADDR_WIDTH = 16,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic                  ENABLE,
  input  logic                  CPOL,
  input  logic                  CPHA,
  input  logic                  SCLK,
  input  logic                  MOSI,
  input  logic                  SS,
  output logic                  MISO,
  output logic                  busy,
  output logic                  overrun,
  output logic                  frame_err,
  output logic [ADDR_WIDTH-1:0] word_count,
  spi_loader_slave_if.master    wr
);
  localparam int BW = $clog2(WORD_WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t                state_q, state_d;
  logic [2:0]            sclk_q;
  logic [2:0]            ss_q;
  logic [1:0]            mosi_q;
  logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]         bitcnt_q, bitcnt_d;
  logic [WORD_WIDTH-1:0] lb_q, lb_d;
  logic                  miso_q, miso_d;
  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0] data_q, data_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  ovr_q, ovr_d;
  logic                  ferr_q, ferr_d;

  logic sclk_rise, sclk_fall, ss_s, ss_rise, mosi_s;
  logic sample_edge, shift_edge, accept;

  // Synchronizers; SS resets high so a frame already running at reset
  // release cannot look like a fresh SS rise.
  always_ff @(posedge clk) begin
    if (RESET) begin
      sclk_q <= '0;
      ss_q   <= '1;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], SCLK};
      ss_q   <= {ss_q[1:0], SS};
      mosi_q <= {mosi_q[0], MOSI};
    end
  end

  assign sclk_rise   =  sclk_q[1] & ~sclk_q[2];
  assign sclk_fall   = ~sclk_q[1] &  sclk_q[2];
  assign ss_s        =  ss_q[1];
  assign ss_rise     =  ss_q[1] & ~ss_q[2];
  assign mosi_s      =  mosi_q[1];
  assign sample_edge = (CPOL ^ CPHA) ? sclk_fall : sclk_rise;
  assign shift_edge  = (CPOL ^ CPHA) ? sclk_rise : sclk_fall;
  assign accept      = valid_q & wr.wr_ready;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      lb_q     <= '0;
      miso_q   <= 1'b0;
      valid_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      lb_q     <= lb_d;
      miso_q   <= miso_d;
      valid_q  <= valid_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      ovr_q    <= ovr_d;
      ferr_q   <= ferr_d;
    end
  end

  // Next state: handshake first (it always retires the old word), then FSM.
  always_comb begin
    logic complete;
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    lb_d     = lb_q;
    miso_d   = miso_q;
    valid_d  = valid_q;
    addr_d   = addr_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    ovr_d    = ovr_q;
    ferr_d   = ferr_q;
    complete = 1'b0;

    if (accept) begin
      valid_d = 1'b0;
      addr_d  = addr_q + 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end

    if (!ENABLE) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (ss_rise) begin
            state_d  = SHIFT;
            bitcnt_d = '0;
            // CPHA=0 needs bit 0 on the wire before the first edge.
            miso_d   = data_q[0];
            lb_d     = CPHA ? data_q : (data_q >> 1);
          end
        end
        SHIFT: begin
          if (!ss_s) begin
            if (bitcnt_q != '0) ferr_d = 1'b1;
            state_d = IDLE;
          end else begin
            if (sample_edge) begin
              shreg_d  = {mosi_s, shreg_q[WORD_WIDTH-1:1]};
              bitcnt_d = bitcnt_q + 1'b1;
              if (bitcnt_q == '1) begin
                complete = 1'b1;
                state_d  = HOLD;
              end
            end
            if (shift_edge) begin
              miso_d = lb_q[0];
              lb_d   = lb_q >> 1;
            end
          end
        end
        HOLD: begin
          if (!ss_s) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    if (complete) begin
      data_d  = {mosi_s, shreg_q[WORD_WIDTH-1:1]};
      valid_d = 1'b1;
      if (valid_q && !accept) ovr_d = 1'b1;
    end
  end

  assign MISO        = ENABLE & miso_q;
  assign busy        = (state_q != IDLE);
  assign overrun     = ovr_q;
  assign frame_err   = ferr_q;
  assign word_count  = cnt_q;
  assign wr.wr_valid = valid_q;
  assign wr.wr_addr  = addr_q;
  assign wr.wr_data  = data_q;
endmodule

// File: tb/tb_spi_loader_slave.sv
// Directed bench for spi_loader_slave: SPI master model at SCLK = clk/8.
module tb_spi_loader_slave;
  logic        clk = 1'b0;
  logic        RESET, ENABLE, CPOL, CPHA, SCLK, MOSI, SS;
  logic        MISO, busy, overrun, frame_err;
  logic [15:0] word_count;
  int          errors = 0;
  int          checks = 0;

  spi_loader_slave_if #(.ADDR_WIDTH(16), .WORD_WIDTH(32)) bus ();

  spi_loader_slave #(.ADDR_WIDTH(16), .WORD_WIDTH(32)) dut (
    .clk(clk), .RESET(RESET), .ENABLE(ENABLE), .CPOL(CPOL), .CPHA(CPHA),
    .SCLK(SCLK), .MOSI(MOSI), .SS(SS), .MISO(MISO), .busy(busy),
    .overrun(overrun), .frame_err(frame_err), .word_count(word_count),
    .wr(bus.master)
  );

  always #5 clk = ~clk;

  // Accepted-write log and longest wr_valid run, cleared by reset.
  logic [15:0] acc_addr[$];
  logic [31:0] acc_data[$];
  int          run = 0;
  int          max_run = 0;
  always @(negedge clk) begin
    if (RESET) begin
      acc_addr.delete();
      acc_data.delete();
      run = 0;
      max_run = 0;
    end else begin
      if (bus.wr_valid && bus.wr_ready) begin
        acc_addr.push_back(bus.wr_addr);
        acc_data.push_back(bus.wr_data);
      end
      if (bus.wr_valid) begin
        run++;
        if (run > max_run) max_run = run;
      end else run = 0;
    end
  end

  task automatic do_reset(input logic cpol, input logic cpha);
    RESET = 1'b1;
    CPOL = cpol; CPHA = cpha; SCLK = cpol; SS = 1'b0; MOSI = 1'b0;
    repeat (3) @(negedge clk);
    RESET = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Master side of one frame; optionally pulses RESET before bit rst_at.
  task automatic send_word(input logic [31:0] d, input int nbits, input int rst_at,
                           output logic [31:0] mi);
    logic [31:0] t;
    mi = '0;
    SCLK = CPOL; SS = 1'b1; MOSI = d[0];
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        RESET = 1'b1; repeat (2) @(negedge clk);
        RESET = 1'b0; repeat (2) @(negedge clk);
      end
      if (!CPHA) begin
        mi[i] = MISO; SCLK = ~CPOL; repeat (4) @(negedge clk);
        t = d >> (i + 1);
        SCLK = CPOL; MOSI = t[0]; repeat (4) @(negedge clk);
      end else begin
        t = d >> i;
        SCLK = ~CPOL; MOSI = t[0]; repeat (4) @(negedge clk);
        mi[i] = MISO; SCLK = CPOL; repeat (4) @(negedge clk);
      end
    end
    SS = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset;
    do_reset(1'b0, 1'b0);
    checks++;
    if ({bus.wr_valid, busy, overrun, frame_err, MISO} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got=%b want=00000", {bus.wr_valid, busy, overrun, frame_err, MISO});
    end
    checks++;
    if (bus.wr_addr !== 16'h0 || word_count !== 16'h0 || bus.wr_data !== 32'h0) begin
      errors++; $display("FAIL reset_regs addr=%h cnt=%h data=%h want zeros", bus.wr_addr, word_count, bus.wr_data);
    end
  endtask

  task automatic test_mode0;
    logic [31:0] m1, m2;
    do_reset(1'b0, 1'b0);
    bus.wr_ready = 1'b1;
    send_word(32'h00000013, 32, -1, m1);
    send_word(32'hDEADBEEF, 32, -1, m2);
    checks++;
    if (acc_addr.size() !== 2) begin
      errors++; $display("FAIL m0_write_count got=%0d want=2", acc_addr.size());
    end else begin
      checks++;
      if (acc_addr[0] !== 16'd0 || acc_data[0] !== 32'h00000013) begin
        errors++; $display("FAIL m0_write0 got=(%h,%h) want=(0000,00000013)", acc_addr[0], acc_data[0]);
      end
      checks++;
      if (acc_addr[1] !== 16'd1 || acc_data[1] !== 32'hDEADBEEF) begin
        errors++; $display("FAIL m0_write1 got=(%h,%h) want=(0001,deadbeef)", acc_addr[1], acc_data[1]);
      end
    end
    checks++;
    if (max_run !== 1) begin
      errors++; $display("FAIL m0_valid_pulse got=%0d want=1", max_run);
    end
    checks++;
    if (word_count !== 16'd2) begin
      errors++; $display("FAIL m0_word_count got=%0d want=2", word_count);
    end
    checks++;
    if (m1 !== 32'h0 || m2 !== 32'h00000013) begin
      errors++; $display("FAIL m0_miso got=%h,%h want=00000000,00000013", m1, m2);
    end
  endtask

  task automatic test_modes;
    logic [31:0] m1, m2;
    for (int md = 1; md < 4; md++) begin
      do_reset(md[1], md[0]);
      bus.wr_ready = 1'b1;
      send_word(32'hA5A5A5A5, 32, -1, m1);
      send_word(32'h3C3C0FF0, 32, -1, m2);
      checks++;
      if (acc_addr.size() !== 2 || acc_addr[0] !== 16'd0 || acc_data[0] !== 32'hA5A5A5A5
          || acc_addr[1] !== 16'd1 || acc_data[1] !== 32'h3C3C0FF0) begin
        errors++; $display("FAIL mode%0d_writes n=%0d first=(%h,%h) want 2 writes (0,a5a5a5a5),(1,3c3c0ff0)",
                           md, acc_addr.size(), bus.wr_addr, bus.wr_data);
      end
      checks++;
      if (m2 !== 32'hA5A5A5A5) begin
        errors++; $display("FAIL mode%0d_miso got=%h want=a5a5a5a5", md, m2);
      end
      checks++;
      if (overrun !== 1'b0 || frame_err !== 1'b0 || max_run !== 1) begin
        errors++; $display("FAIL mode%0d_flags ovr=%b ferr=%b run=%0d want 0,0,1", md, overrun, frame_err, max_run);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] m;
    bit stable;
    do_reset(1'b0, 1'b0);
    bus.wr_ready = 1'b0;
    send_word(32'h12345678, 32, -1, m);
    stable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (bus.wr_valid !== 1'b1 || bus.wr_addr !== 16'd0 || bus.wr_data !== 32'h12345678) stable = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (!stable) begin
      errors++; $display("FAIL bp_hold valid=%b addr=%h data=%h want 1,0000,12345678 held", bus.wr_valid, bus.wr_addr, bus.wr_data);
    end
    bus.wr_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.wr_valid !== 1'b0 || bus.wr_addr !== 16'd1 || word_count !== 16'd1) begin
      errors++; $display("FAIL bp_accept valid=%b addr=%h cnt=%h want 0,0001,0001", bus.wr_valid, bus.wr_addr, word_count);
    end
    checks++;
    if (acc_data.size() !== 1 || acc_data[0] !== 32'h12345678) begin
      errors++; $display("FAIL bp_data n=%0d want one write of 12345678", acc_data.size());
    end
  endtask

  task automatic test_overrun;
    logic [31:0] m;
    do_reset(1'b0, 1'b0);
    bus.wr_ready = 1'b0;
    send_word(32'h00000001, 32, -1, m);
    send_word(32'h00000002, 32, -1, m);
    checks++;
    if (overrun !== 1'b1 || bus.wr_valid !== 1'b1 || bus.wr_data !== 32'h2 || bus.wr_addr !== 16'd0) begin
      errors++; $display("FAIL overrun ovr=%b valid=%b data=%h addr=%h want 1,1,00000002,0000",
                         overrun, bus.wr_valid, bus.wr_data, bus.wr_addr);
    end
    bus.wr_ready = 1'b1;
  endtask

  task automatic test_frame_err;
    logic [31:0] m;
    do_reset(1'b0, 1'b0);
    bus.wr_ready = 1'b1;
    send_word(32'h0001FFFF, 17, -1, m);
    checks++;
    if (frame_err !== 1'b1 || acc_addr.size() !== 0) begin
      errors++; $display("FAIL ferr_partial ferr=%b writes=%0d want 1,0", frame_err, acc_addr.size());
    end
    send_word(32'hCAFEF00D, 32, -1, m);
    checks++;
    if (acc_addr.size() !== 1 || acc_addr[0] !== 16'd0 || acc_data[0] !== 32'hCAFEF00D) begin
      errors++; $display("FAIL ferr_next n=%0d addr=%h data=%h want 1 write (0000,cafef00d)",
                         acc_addr.size(), bus.wr_addr, bus.wr_data);
    end
  endtask

  task automatic test_reset_midframe;
    logic [31:0] m;
    do_reset(1'b0, 1'b0);
    bus.wr_ready = 1'b1;
    send_word(32'hFFFFFFFF, 32, 10, m);
    checks++;
    if (acc_addr.size() !== 0 || bus.wr_valid !== 1'b0 || word_count !== 16'd0) begin
      errors++; $display("FAIL rst_mid_drop writes=%0d valid=%b cnt=%0d want 0,0,0", acc_addr.size(), bus.wr_valid, word_count);
    end
    send_word(32'h0BADC0DE, 32, -1, m);
    checks++;
    if (acc_addr.size() !== 1 || acc_addr[0] !== 16'd0 || acc_data[0] !== 32'h0BADC0DE) begin
      errors++; $display("FAIL rst_mid_next n=%0d addr=%h data=%h want 1 write (0000,0badc0de)",
                         acc_addr.size(), bus.wr_addr, bus.wr_data);
    end
  endtask

  initial begin
    RESET = 1'b1; ENABLE = 1'b1; CPOL = 1'b0; CPHA = 1'b0;
    SCLK = 1'b0; MOSI = 1'b0; SS = 1'b0;
    bus.wr_ready = 1'b1;
    test_reset();
    test_mode0();
    test_modes();
    test_backpressure();
    test_overrun();
    test_frame_err();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
